// File: rtl/exu_if.sv
// Operand/result bundle between the register bank side and the exu.
// The slave modport is the exu's view; master is the driver's view.
interface exu_if;
    logic        go_in;
    logic [3:0]  op_in;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  rd_in;
    logic [15:0] d_out;
    logic        rw_out;
    logic [3:0]  rd_out;
    logic        busy_out;
    logic [2:0]  flags_out;

    modport slave (
        input  go_in, op_in, a_in, b_in, rd_in,
        output d_out, rw_out, rd_out, busy_out, flags_out
    );

    modport master (
        output go_in, op_in, a_in, b_in, rd_in,
        input  d_out, rw_out, rd_out, busy_out, flags_out
    );
endinterface

// File: rtl/exu.sv
// Execution unit: single-cycle ALU ops with registered write-back, plus a
// 16-iteration shift-add multiplier and a {Z,N,C} status register.
module exu (
    input  logic clk,
    input  logic rst_n,
    exu_if.slave bus
);
    typedef enum logic {IDLE, MUL} state_e;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
        OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
        OP_ASR = 4'd8, OP_MOV = 4'd9, OP_MUL = 4'd10, OP_CMP = 4'd11
    } op_e;

    state_e      state_q, state_d;
    logic [15:0] d_q, d_d;
    logic        rw_q, rw_d;
    logic [3:0]  rd_q, rd_d;
    logic [2:0]  flags_q, flags_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] a_ext_q, a_ext_d;
    logic [15:0] b_shift_q, b_shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  mrd_q, mrd_d;

    logic [15:0]        res;
    logic               c;
    logic               wr, upd;
    logic [16:0]        sum_w;
    logic [31:0]        shl_w, shr_w;
    logic signed [31:0] asr_w;
    logic [31:0]        acc_next;

    always_comb begin
        res   = '0;
        c     = 1'b0;
        wr    = 1'b1;
        upd   = 1'b1;
        sum_w = {1'b0, bus.a_in} + {1'b0, bus.b_in};
        // Shifts run through a 32-bit window so the last bit shifted out
        // lands at a fixed position; shift amount 0 leaves that bit clear.
        shl_w = {16'h0000, bus.a_in} << bus.b_in[3:0];
        shr_w = {bus.a_in, 16'h0000} >> bus.b_in[3:0];
        asr_w = $signed({bus.a_in, 16'h0000}) >>> bus.b_in[3:0];
        case (op_e'(bus.op_in))
            OP_ADD: begin res = sum_w[15:0]; c = sum_w[16]; end
            OP_SUB: begin res = bus.a_in - bus.b_in; c = bus.a_in < bus.b_in; end
            OP_AND: res = bus.a_in & bus.b_in;
            OP_OR:  res = bus.a_in | bus.b_in;
            OP_XOR: res = bus.a_in ^ bus.b_in;
            OP_NOT: res = ~bus.a_in;
            OP_SHL: begin res = shl_w[15:0]; c = shl_w[16]; end
            OP_SHR: begin res = shr_w[31:16]; c = shr_w[15]; end
            OP_ASR: begin res = asr_w[31:16]; c = asr_w[15]; end
            OP_MOV: res = bus.b_in;
            OP_CMP: begin res = bus.a_in - bus.b_in; c = bus.a_in < bus.b_in; wr = 1'b0; end
            default: begin wr = 1'b0; upd = 1'b0; end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        rw_d      = 1'b0;
        rd_d      = rd_q;
        flags_d   = flags_q;
        acc_d     = acc_q;
        a_ext_d   = a_ext_q;
        b_shift_d = b_shift_q;
        cnt_d     = cnt_q;
        mrd_d     = mrd_q;
        acc_next  = acc_q + (b_shift_q[0] ? a_ext_q : 32'h0);
        case (state_q)
            IDLE: begin
                if (bus.go_in) begin
                    if (op_e'(bus.op_in) == OP_MUL) begin
                        state_d   = MUL;
                        acc_d     = '0;
                        cnt_d     = '0;
                        a_ext_d   = {16'h0000, bus.a_in};
                        b_shift_d = bus.b_in;
                        mrd_d     = bus.rd_in;
                    end else begin
                        if (wr) begin
                            d_d  = res;
                            rd_d = bus.rd_in;
                            rw_d = 1'b1;
                        end
                        if (upd)
                            flags_d = {res == 16'h0000, res[15], c};
                    end
                end
            end
            MUL: begin
                acc_d     = acc_next;
                a_ext_d   = a_ext_q << 1;
                b_shift_d = b_shift_q >> 1;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = IDLE;
                    d_d     = acc_next[15:0];
                    rd_d    = mrd_q;
                    rw_d    = 1'b1;
                    flags_d = {acc_next[15:0] == 16'h0000, acc_next[15],
                               acc_next[31:16] != 16'h0000};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            d_q       <= '0;
            rw_q      <= 1'b0;
            rd_q      <= '0;
            flags_q   <= '0;
            acc_q     <= '0;
            a_ext_q   <= '0;
            b_shift_q <= '0;
            cnt_q     <= '0;
            mrd_q     <= '0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            rw_q      <= rw_d;
            rd_q      <= rd_d;
            flags_q   <= flags_d;
            acc_q     <= acc_d;
            a_ext_q   <= a_ext_d;
            b_shift_q <= b_shift_d;
            cnt_q     <= cnt_d;
            mrd_q     <= mrd_d;
        end
    end

    assign bus.d_out     = d_q;
    assign bus.rw_out    = rw_q;
    assign bus.rd_out    = rd_q;
    assign bus.busy_out  = (state_q == MUL);
    assign bus.flags_out = flags_q;
endmodule

// File: tb/tb_exu.sv
// Directed bench for exu: vector table for single-cycle ops, hand-written
// sequences for multiply timing, busy-time go filtering and mid-MUL reset.
module tb_exu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    exu_if bus ();

    exu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  rd;
        logic [15:0] exp_d;
        logic        exp_rw;
        logic [3:0]  exp_rd;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for exactly one cycle; returns sampled #1 after the edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] rd);
        bus.go_in = 1'b1;
        bus.op_in = op;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.rd_in = rd;
        tick();
        bus.go_in = 1'b0;
    endtask

    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [3:0] rd,
                           input logic [15:0] exp_d, input logic [2:0] exp_f,
                           input bit inject);
        int n = 0;
        int extra_rw = 0;
        issue(4'd10, a, b, rd);
        while (bus.busy_out && n < 40) begin
            if (bus.rw_out) extra_rw++;
            if (inject && n == 3) begin
                bus.a_in = 16'hFFFF;
                bus.b_in = 16'hFFFF;
            end
            if (inject && n == 5) begin
                bus.go_in = 1'b1;
                bus.op_in = 4'd0;
                bus.rd_in = 4'd7;
            end
            if (inject && n == 6) bus.go_in = 1'b0;
            n++;
            tick();
        end
        chk("mul_busy_cycles", n, 16);
        chk("mul_no_rw_while_busy", extra_rw, 0);
        chk("mul_rw", bus.rw_out, 1'b1);
        chk("mul_d", bus.d_out, exp_d);
        chk("mul_rd", bus.rd_out, rd);
        chk("mul_flags", bus.flags_out, exp_f);
    endtask

    initial begin
        bus.go_in = 1'b0;
        bus.op_in = '0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.rd_in = '0;

        vecs[0]  = '{4'd0,  16'hFFFF, 16'h0001, 4'd3,  16'h0000, 1'b1, 4'd3,  3'b101};
        vecs[1]  = '{4'd1,  16'h0005, 16'h0007, 4'd4,  16'hFFFE, 1'b1, 4'd4,  3'b011};
        vecs[2]  = '{4'd2,  16'hF0F0, 16'h3C3C, 4'd5,  16'h3030, 1'b1, 4'd5,  3'b000};
        vecs[3]  = '{4'd3,  16'hF0F0, 16'h0F0F, 4'd6,  16'hFFFF, 1'b1, 4'd6,  3'b010};
        vecs[4]  = '{4'd4,  16'hAAAA, 16'hAAAA, 4'd7,  16'h0000, 1'b1, 4'd7,  3'b100};
        vecs[5]  = '{4'd5,  16'h00FF, 16'h1234, 4'd8,  16'hFF00, 1'b1, 4'd8,  3'b010};
        vecs[6]  = '{4'd7,  16'h8001, 16'h0001, 4'd9,  16'h4000, 1'b1, 4'd9,  3'b001};
        vecs[7]  = '{4'd8,  16'h8000, 16'h0004, 4'd10, 16'hF800, 1'b1, 4'd10, 3'b010};
        vecs[8]  = '{4'd6,  16'h1234, 16'h0000, 4'd11, 16'h1234, 1'b1, 4'd11, 3'b000};
        vecs[9]  = '{4'd6,  16'hC001, 16'h0002, 4'd12, 16'h0004, 1'b1, 4'd12, 3'b001};
        vecs[10] = '{4'd9,  16'h0000, 16'h8000, 4'd13, 16'h8000, 1'b1, 4'd13, 3'b010};
        vecs[11] = '{4'd11, 16'h0005, 16'h0007, 4'd1,  16'h8000, 1'b0, 4'd13, 3'b011};
        vecs[12] = '{4'd15, 16'h0000, 16'h0000, 4'd2,  16'h8000, 1'b0, 4'd13, 3'b011};
        vecs[13] = '{4'd0,  16'h7FFF, 16'h0001, 4'd14, 16'h8000, 1'b1, 4'd14, 3'b010};
        vecs[14] = '{4'd1,  16'h0003, 16'h0003, 4'd15, 16'h0000, 1'b1, 4'd15, 3'b100};

        tick();
        tick();
        chk("rst_d", bus.d_out, 16'h0000);
        chk("rst_rw", bus.rw_out, 1'b0);
        chk("rst_rd", bus.rd_out, 4'd0);
        chk("rst_busy", bus.busy_out, 1'b0);
        chk("rst_flags", bus.flags_out, 3'b000);
        rst_n = 1'b1;
        tick();

        // Single ADD then idle: the write pulse must last exactly one cycle.
        issue(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].rd);
        chk("add_pulse_rw", bus.rw_out, 1'b1);
        tick();
        chk("add_pulse_end", bus.rw_out, 1'b0);

        // Table issued back-to-back, one op per clock.
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            chk($sformatf("vec%0d_d", i), bus.d_out, vecs[i].exp_d);
            chk($sformatf("vec%0d_rw", i), bus.rw_out, vecs[i].exp_rw);
            chk($sformatf("vec%0d_rd", i), bus.rd_out, vecs[i].exp_rd);
            chk($sformatf("vec%0d_flags", i), bus.flags_out, vecs[i].exp_flags);
        end
        tick();

        // MUL with operand changes and an ignored ADD during busy.
        run_mul(16'h0123, 16'h0010, 4'd2, 16'h1230, 3'b000, 1'b1);
        // ADD issued in the MUL write-pulse cycle is accepted.
        issue(4'd0, 16'h0001, 16'h0001, 4'd9);
        chk("b2b_add_rw", bus.rw_out, 1'b1);
        chk("b2b_add_d", bus.d_out, 16'h0002);
        chk("b2b_add_rd", bus.rd_out, 4'd9);
        chk("b2b_add_flags", bus.flags_out, 3'b000);
        tick();
        chk("b2b_add_end", bus.rw_out, 1'b0);

        run_mul(16'h8000, 16'h0002, 4'd5, 16'h0000, 3'b101, 1'b0);
        tick();

        // Reset at MUL iteration 8 aborts the op with no write pulse.
        begin
            int rw_seen = 0;
            issue(4'd10, 16'h0003, 16'h0005, 4'd6);
            for (int i = 0; i < 8; i++) tick();
            chk("abort_busy_before", bus.busy_out, 1'b1);
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            chk("abort_d", bus.d_out, 16'h0000);
            chk("abort_rw", bus.rw_out, 1'b0);
            chk("abort_rd", bus.rd_out, 4'd0);
            chk("abort_busy", bus.busy_out, 1'b0);
            chk("abort_flags", bus.flags_out, 3'b000);
            for (int i = 0; i < 24; i++) begin
                if (bus.rw_out) rw_seen++;
                tick();
            end
            chk("abort_no_rw", rw_seen, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
